uart_fifo_bridge: RTL and testbench
===================================

# uart_fifo_bridge

Parametrised, buffered bridge between the core's byte-stream ports and the UART send/receive handshakes at the top wrapper boundary. It replaces the core's direct single-byte UART coupling with two independent FIFOs (send and receive) of configurable width and depth, so that the core can burst output and the UART can deliver bursts of input without stalling each other. It is instantiated inside the top wrapper, between the core and the UART pins.

## Interface
- DATA_W, default 8: byte/word width of both paths.
- DEPTH, default 16: entries per FIFO; power of two, ≥ 2.
- CNT_W, derived, $clog2(DEPTH)+1: width of the occupancy counters.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  core byte to send.
- tx_valid  in  1  core offers tx_data.
- tx_ready  out  1  send FIFO not full; push occurs when tx_valid & tx_ready.
- rx_data  out  DATA_W  head of receive FIFO.
- rx_valid  out  1  receive FIFO not empty.
- rx_ready  in  1  core consumes head; pop occurs when rx_valid & rx_ready.
- uart_send_data  out  DATA_W  head of send FIFO.
- uart_send_ready  out  1  send FIFO not empty (byte available to UART).
- uart_send_valid  in  1  UART takes the byte this cycle; pop when uart_send_ready & uart_send_valid.
- uart_recv_data  in  DATA_W  byte from UART.
- uart_recv_valid  in  1  UART offers a byte.
- uart_recv_ready  out  1  receive FIFO not full; push when uart_recv_valid & uart_recv_ready.
- tx_count  out  CNT_W  send FIFO occupancy.
- rx_count  out  CNT_W  receive FIFO occupancy.

## Operation
- Each FIFO is first-word-fall-through: head data is driven combinationally from the storage array at the read pointer; pointers and count are registered.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH; full = (count == DEPTH), empty = (count == 0).
- Push accepted only when not full; pop only when not empty. A push into a full FIFO is impossible because ready is low; an ignored valid is not an error.
- Simultaneous push and pop: both pointers advance, count unchanged. When full, only a pop is possible, because ready is low. When empty, only the push takes effect and the pushed data is not bypassed to the output.
- Storage contents are not reset; only pointers and counts are reset.
- Signals marked out-of-handshake (e.g. data while valid is low) are don't-care to the bench.

## Timing
- Reset (rstn low, asynchronous): counts 0, pointers 0.
  - Resulting outputs: tx_ready=1, uart_recv_ready=1, rx_valid=0, uart_send_ready=0, tx_count=rx_count=0.
  - Asserting reset mid-transfer discards all buffered data.
- Latency: a byte pushed at edge N is visible at the FIFO output (valid=1) after edge N, i.e. in cycle N+1. Minimum pass-through is 1 cycle.
- Throughput: one push and one pop per FIFO per cycle, sustained, including at the full and empty boundaries where legal.
- Counts update on the same edge as the push/pop.
- ready/valid outputs are functions of registered count only. No combinational path exists from any input valid/ready to any output ready/valid.

## Configuration
- UART_BRIDGE_LOOPBACK_EN:
  - Defined: adds input port loopback (1 bit). While loopback=1:
    - Send-FIFO head feeds receive-FIFO push: pop/push when send not empty and receive not full, in the same cycle.
    - uart_send_ready=0 and uart_recv_ready=0, so the UART sees nothing.
    - uart_recv_valid is ignored.
  - Changing loopback takes effect on the next cycle. A handshake in progress in the current cycle completes under the old mode.
  - Not defined: no loopback port; paths are always external.

## Structure
- Package uart_bridge_pkg holds:
  - default DATA_W and DEPTH constants;
  - a typedef for the count type, parametrised via CNT_W function;
  - the function computing CNT_W.
- One sub-module, sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/count/head), is instantiated twice. The top adds only handshake mapping and the loopback mux.

## Test plan
- Reset then idle → tx_ready=1, uart_recv_ready=1, rx_valid=0, uart_send_ready=0, counts 0.
- Push 0x41 on tx with uart_send_valid=0 → next cycle uart_send_ready=1, uart_send_data=0x41, tx_count=1; then assert uart_send_valid for one cycle → tx_count=0.
- Push 16 bytes 0x00..0x0F with DEPTH=16 and no UART pops → tx_ready=0 after 16th edge; 17th offer ignored; drain yields 0x00..0x0F in order, exercising pointer wrap on a second fill.
- Receive FIFO at 15 entries, simultaneous uart_recv push and core pop each cycle for 40 cycles → rx_count stays 15, order preserved, uart_recv_ready never drops.
- Assert rstn low with tx_count=5 and rx_count=3 → outputs return to reset values immediately, without waiting for clk; buffered bytes never appear after reset release.
- With UART_BRIDGE_LOOPBACK_EN and loopback=1, push 0xA5,0x5A → rx_data returns 0xA5 then 0x5A, first available 2 cycles after push; uart_send_ready stays 0.

Source files
------------

// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants, count type and width helper for the UART FIFO bridge.
// Optional loopback path is enabled with UART_BRIDGE_LOOPBACK_EN.
package uart_bridge_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Occupancy must represent 0..DEPTH inclusive, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [cnt_w(DEPTH_DEF)-1:0] count_t;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Handshake bundle between core, bridge and UART.
// The slave modport is the bridge side; master is the core/UART side.
interface uart_fifo_bridge_if
    import uart_bridge_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    logic [DATA_W-1:0] uart_send_data;
    logic              uart_send_ready;
    logic              uart_send_valid;

    logic [DATA_W-1:0] uart_recv_data;
    logic              uart_recv_valid;
    logic              uart_recv_ready;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output uart_send_data,
        output uart_send_ready,
        input  uart_send_valid,
        input  uart_recv_data,
        input  uart_recv_valid,
        output uart_recv_ready
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  uart_send_data,
        input  uart_send_ready,
        output uart_send_valid,
        output uart_recv_data,
        output uart_recv_valid,
        input  uart_recv_ready
    );

endinterface

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered pointers/count.
// Storage is deliberately left out of reset.
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                do_push & ~do_pop: count <= count + 1'b1;
                do_pop & ~do_push: count <= count - 1'b1;
                default:           count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered core<->UART bridge: one send FIFO and one receive FIFO.
// Define UART_BRIDGE_LOOPBACK_EN to add the send->receive loopback port.
module uart_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
`ifdef UART_BRIDGE_LOOPBACK_EN
    input  logic               loopback,
`endif
    uart_fifo_bridge_if.slave  bus,
    output logic [CNT_W-1:0]   tx_count,
    output logic [CNT_W-1:0]   rx_count
);

    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_head;

    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_head;
    logic [DATA_W-1:0] rx_wdata;

    logic              lb_q;
    logic              lb_move;

    // Mode is registered so a mid-cycle change never splits a handshake.
`ifdef UART_BRIDGE_LOOPBACK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lb_q <= 1'b0;
        end else begin
            lb_q <= loopback;
        end
    end
`else
    assign lb_q = 1'b0;
`endif

    assign lb_move  = lb_q & ~tx_empty & ~rx_full;

    assign tx_push  = bus.tx_valid & ~tx_full;
    assign tx_pop   = lb_q ? lb_move
                           : (bus.uart_send_valid & ~tx_empty);
    assign rx_push  = lb_q ? lb_move
                           : (bus.uart_recv_valid & ~rx_full);
    assign rx_wdata = lb_q ? tx_head : bus.uart_recv_data;
    assign rx_pop   = bus.rx_ready & ~rx_empty;

    assign bus.tx_ready        = ~tx_full;
    assign bus.uart_send_data  = tx_head;
    assign bus.uart_send_ready = ~lb_q & ~tx_empty;
    assign bus.uart_recv_ready = ~lb_q & ~rx_full;
    assign bus.rx_data         = rx_head;
    assign bus.rx_valid        = ~rx_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_send (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .wdata (bus.tx_data),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_recv (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_push),
        .wdata (rx_wdata),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge against a queue-based model.
// Loopback scenarios are compiled in with UART_BRIDGE_LOOPBACK_EN.
module tb_uart_fifo_bridge;
    import uart_bridge_pkg::*;

    localparam int DEPTH = DEPTH_DEF;

    logic   clk  = 1'b0;
    logic   rstn = 1'b0;
    count_t tx_count;
    count_t rx_count;
`ifdef UART_BRIDGE_LOOPBACK_EN
    logic   loopback = 1'b0;
`endif

    uart_fifo_bridge_if bus ();

    int errors = 0;
    int checks = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         lb_cur = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_bridge dut (
        .clk      (clk),
        .rstn     (rstn),
`ifdef UART_BRIDGE_LOOPBACK_EN
        .loopback (loopback),
`endif
        .bus      (bus),
        .tx_count (tx_count),
        .rx_count (rx_count)
    );

    task automatic idle();
        bus.tx_data         = 8'h00;
        bus.tx_valid        = 1'b0;
        bus.rx_ready        = 1'b0;
        bus.uart_send_valid = 1'b0;
        bus.uart_recv_data  = 8'h00;
        bus.uart_recv_valid = 1'b0;
    endtask

    // One clock edge: model decides handshakes from its own occupancy.
    task automatic tick();
        bit         tpush, tpop, rpush, rpop;
        logic [7:0] td, rd;
        tpush = bus.tx_valid && (txq.size() < DEPTH);
        td    = bus.tx_data;
        rpop  = bus.rx_ready && (rxq.size() > 0);
        if (lb_cur) begin
            tpop  = (txq.size() > 0) && (rxq.size() < DEPTH);
            rpush = tpop;
            rd    = tpop ? txq[0] : 8'h00;
        end else begin
            tpop  = bus.uart_send_valid && (txq.size() > 0);
            rpush = bus.uart_recv_valid && (rxq.size() < DEPTH);
            rd    = bus.uart_recv_data;
        end
        @(posedge clk);
`ifdef UART_BRIDGE_LOOPBACK_EN
        lb_cur = loopback;
`endif
        if (tpop)  void'(txq.pop_front());
        if (rpop)  void'(rxq.pop_front());
        if (tpush) txq.push_back(td);
        if (rpush) rxq.push_back(rd);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset tx_ready got %b want 1", bus.tx_ready);
        end
        checks++;
        if (bus.uart_recv_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset uart_recv_ready got %b want 1",
                     bus.uart_recv_ready);
        end
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset rx_valid got %b want 0", bus.rx_valid);
        end
        checks++;
        if (bus.uart_send_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset uart_send_ready got %b want 0",
                     bus.uart_send_ready);
        end
        checks++;
        if (tx_count !== '0 || rx_count !== '0) begin
            errors++;
            $display("FAIL reset counts got %0d/%0d want 0/0",
                     tx_count, rx_count);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        idle();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h41;
        tick();
        idle();
        checks++;
        if (bus.uart_send_ready !== 1'b1 || bus.uart_send_data !== 8'h41) begin
            errors++;
            $display("FAIL single head got rdy=%b data=%h want rdy=1 data=41",
                     bus.uart_send_ready, bus.uart_send_data);
        end
        checks++;
        if (tx_count !== 5'd1) begin
            errors++;
            $display("FAIL single tx_count got %0d want 1", tx_count);
        end
        bus.uart_send_valid = 1'b1;
        tick();
        idle();
        checks++;
        if (tx_count !== 5'd0 || bus.uart_send_ready !== 1'b0) begin
            errors++;
            $display("FAIL single drain got cnt=%0d rdy=%b want 0/0",
                     tx_count, bus.uart_send_ready);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] base;
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            idle();
            for (int i = 0; i < DEPTH; i++) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = base + 8'(i);
                tick();
            end
            checks++;
            if (bus.tx_ready !== 1'b0 || int'(tx_count) != DEPTH) begin
                errors++;
                $display("FAIL fill full got rdy=%b cnt=%0d want 0/%0d",
                         bus.tx_ready, tx_count, DEPTH);
            end
            bus.tx_data = 8'hFF;
            tick();
            checks++;
            if (int'(tx_count) != DEPTH) begin
                errors++;
                $display("FAIL fill overflow cnt got %0d want %0d",
                         tx_count, DEPTH);
            end
            idle();
            bus.uart_send_valid = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (bus.uart_send_ready !== 1'b1
                    || bus.uart_send_data !== base + 8'(i)) begin
                    errors++;
                    $display("FAIL drain[%0d] got rdy=%b data=%h want 1/%h",
                             i, bus.uart_send_ready, bus.uart_send_data,
                             base + 8'(i));
                end
                tick();
            end
            checks++;
            if (tx_count !== '0 || bus.uart_send_ready !== 1'b0) begin
                errors++;
                $display("FAIL drain empty got cnt=%0d rdy=%b want 0/0",
                         tx_count, bus.uart_send_ready);
            end
            idle();
        end
    endtask

    task automatic test_rx_steady();
        idle();
        for (int i = 0; i < DEPTH - 1; i++) begin
            bus.uart_recv_valid = 1'b1;
            bus.uart_recv_data  = 8'($urandom);
            tick();
        end
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.uart_recv_data = 8'($urandom);
            checks++;
            if (int'(rx_count) != DEPTH - 1 || bus.uart_recv_ready !== 1'b1) begin
                errors++;
                $display("FAIL steady[%0d] got cnt=%0d rdy=%b want %0d/1",
                         i, rx_count, bus.uart_recv_ready, DEPTH - 1);
            end
            checks++;
            if (bus.rx_valid !== 1'b1 || bus.rx_data !== rxq[0]) begin
                errors++;
                $display("FAIL steady_data[%0d] got %h want %h",
                         i, bus.rx_data, rxq[0]);
            end
            tick();
        end
        bus.uart_recv_valid = 1'b0;
        while (rxq.size() > 0) tick();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.tx_valid        = 1'b1;
            bus.tx_data         = 8'($urandom);
            bus.uart_recv_valid = (i < 3);
            bus.uart_recv_data  = 8'($urandom);
            tick();
        end
        idle();
        checks++;
        if (tx_count !== 5'd5 || rx_count !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset counts got %0d/%0d want 5/3",
                     tx_count, rx_count);
        end
        #2 rstn = 1'b0;
        #1;
        txq.delete();
        rxq.delete();
        lb_cur = 1'b0;
        checks++;
        if (tx_count !== '0 || rx_count !== '0 || bus.rx_valid !== 1'b0
            || bus.uart_send_ready !== 1'b0 || bus.tx_ready !== 1'b1
            || bus.uart_recv_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d/%0d rv=%b sr=%b tr=%b ur=%b want 0/0 0 0 1 1",
                     tx_count, rx_count, bus.rx_valid, bus.uart_send_ready,
                     bus.tx_ready, bus.uart_recv_ready);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.rx_ready        = 1'b1;
        bus.uart_send_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.uart_send_ready !== 1'b0
            || tx_count !== '0 || rx_count !== '0) begin
            errors++;
            $display("FAIL post_reset got rv=%b sr=%b cnt=%0d/%0d want 0 0 0/0",
                     bus.rx_valid, bus.uart_send_ready, tx_count, rx_count);
        end
        idle();
    endtask

`ifdef UART_BRIDGE_LOOPBACK_EN
    task automatic test_loopback();
        idle();
        loopback = 1'b1;
        tick();
        bus.uart_recv_valid = 1'b1;
        bus.uart_recv_data  = 8'($urandom);
        bus.uart_send_valid = 1'b1;
        bus.tx_valid        = 1'b1;
        bus.tx_data         = 8'hA5;
        tick();
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.uart_send_ready !== 1'b0) begin
            errors++;
            $display("FAIL lb_first got rv=%b sr=%b want 0/0",
                     bus.rx_valid, bus.uart_send_ready);
        end
        bus.tx_data = 8'h5A;
        tick();
        bus.tx_valid = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL lb_a5 got rv=%b data=%h want 1/a5",
                     bus.rx_valid, bus.rx_data);
        end
        tick();
        checks++;
        if (rx_count !== 5'd2 || bus.uart_send_ready !== 1'b0
            || bus.uart_recv_ready !== 1'b0) begin
            errors++;
            $display("FAIL lb_hold got cnt=%0d sr=%b ur=%b want 2/0/0",
                     rx_count, bus.uart_send_ready, bus.uart_recv_ready);
        end
        bus.rx_ready = 1'b1;
        tick();
        checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL lb_5a got rv=%b data=%h want 1/5a",
                     bus.rx_valid, bus.rx_data);
        end
        tick();
        idle();
        loopback = 1'b0;
        tick();
        checks++;
        if (bus.rx_valid !== 1'b0 || bus.uart_recv_ready !== 1'b1) begin
            errors++;
            $display("FAIL lb_exit got rv=%b ur=%b want 0/1",
                     bus.rx_valid, bus.uart_recv_ready);
        end
    endtask
`endif

    task automatic test_random();
        int push_pct;
        int pop_pct;
        idle();
        for (int c = 0; c < 600; c++) begin
            push_pct = ((c / 150) % 2 == 0) ? 80 : 30;
            pop_pct  = 110 - push_pct;
            bus.tx_valid        = ($urandom_range(0, 99) < push_pct);
            bus.tx_data         = 8'($urandom);
            bus.uart_recv_valid = ($urandom_range(0, 99) < push_pct);
            bus.uart_recv_data  = 8'($urandom);
            bus.uart_send_valid = ($urandom_range(0, 99) < pop_pct);
            bus.rx_ready        = ($urandom_range(0, 99) < pop_pct);
`ifdef UART_BRIDGE_LOOPBACK_EN
            if ($urandom_range(0, 29) == 0) loopback = ~loopback;
`endif
            checks++;
            if (int'(tx_count) != txq.size() || int'(rx_count) != rxq.size()) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d",
                         c, tx_count, rx_count, txq.size(), rxq.size());
            end
            checks++;
            if (bus.tx_ready !== (txq.size() < DEPTH)
                || bus.rx_valid !== (rxq.size() > 0)
                || bus.uart_send_ready !== (!lb_cur && txq.size() > 0)
                || bus.uart_recv_ready !== (!lb_cur && rxq.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_hs[%0d] got tr=%b rv=%b sr=%b ur=%b",
                         c, bus.tx_ready, bus.rx_valid,
                         bus.uart_send_ready, bus.uart_recv_ready);
            end
            if (txq.size() > 0) begin
                checks++;
                if (bus.uart_send_data !== txq[0]) begin
                    errors++;
                    $display("FAIL rand_tx[%0d] got %h want %h",
                             c, bus.uart_send_data, txq[0]);
                end
            end
            if (rxq.size() > 0) begin
                checks++;
                if (bus.rx_data !== rxq[0]) begin
                    errors++;
                    $display("FAIL rand_rx[%0d] got %h want %h",
                             c, bus.rx_data, rxq[0]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_fill_drain();
        test_rx_steady();
        test_async_reset();
`ifdef UART_BRIDGE_LOOPBACK_EN
        test_loopback();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
